// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: pipelined HSV -> RGB888 converter at the tail of the HSV filter
// chain. Input pixel is {H[23:15], S[14:8], V[7:0]}, output is {R,G,B}.
// A sideband word and a valid flag ride alongside with identical latency, and
// a per-pixel enable selects conversion or verbatim bypass.
//
// Register layout (sample taken at edge k is visible after edge k+4):
//   edge k   : input capture
//   edge k+1 : hue normalisation, sector and offset inside the sector
//   edge k+2 : chroma C and the ramp distance t
//   edge k+3 : secondary component X and the grey offset m
//   edge k+4 : sector-mapped channels plus m (or the bypassed pixel)

module hsv_to_rgb #(
  parameter int unsigned PASS_W  = 24,
  parameter int unsigned RECIP60 = 1093
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [23:0]       pixel_in,
  input  logic [PASS_W-1:0] pass_in,
  output logic [23:0]       pixel_out,
  output logic [PASS_W-1:0] pass_thru,
  output logic              out_valid
);

  // ---------------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------------
  logic              s0_valid;
  logic              s0_en;
  logic [23:0]       s0_pixel;
  logic [PASS_W-1:0] s0_pass;

  // Capture valid and sideband; both are flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_pass  <= '0;
    end else begin
      s0_valid <= in_valid;
      s0_pass  <= pass_in;
    end
  end

  // Capture the pixel and its enable; bubble contents are don't-care.
  always_ff @(posedge clk) begin
    s0_en    <= en;
    s0_pixel <= pixel_in;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: hue wrap, sector select, offset within sector
  // ---------------------------------------------------------------------------
  logic [8:0] h_raw;
  logic [8:0] h_norm;
  logic [2:0] sector;
  logic [8:0] sector_base;
  logic [5:0] hue_offset;

  assign h_raw      = s0_pixel[23:15];
  assign h_norm     = (h_raw >= 9'd360) ? (h_raw - 9'd360) : h_raw;
  assign hue_offset = 6'(h_norm - sector_base);

  // Divide the normalised hue by 60 with a compare ladder instead of a divider.
  always_comb begin
    sector      = 3'd5;
    sector_base = 9'd300;
    if (h_norm < 9'd60) begin
      sector      = 3'd0;
      sector_base = 9'd0;
    end else if (h_norm < 9'd120) begin
      sector      = 3'd1;
      sector_base = 9'd60;
    end else if (h_norm < 9'd180) begin
      sector      = 3'd2;
      sector_base = 9'd120;
    end else if (h_norm < 9'd240) begin
      sector      = 3'd3;
      sector_base = 9'd180;
    end else if (h_norm < 9'd300) begin
      sector      = 3'd4;
      sector_base = 9'd240;
    end
  end

  logic              s1_valid;
  logic              s1_en;
  logic [23:0]       s1_pixel;
  logic [PASS_W-1:0] s1_pass;
  logic [2:0]        s1_sector;
  logic [5:0]        s1_f;
  logic [6:0]        s1_s;
  logic [7:0]        s1_v;

  // Advance valid and sideband into stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pass  <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_pass  <= s0_pass;
    end
  end

  // Register sector, offset and the saturation/value fields.
  always_ff @(posedge clk) begin
    s1_en     <= s0_en;
    s1_pixel  <= s0_pixel;
    s1_sector <= sector;
    s1_f      <= hue_offset;
    s1_s      <= s0_pixel[14:8];
    s1_v      <= s0_pixel[7:0];
  end

  // ---------------------------------------------------------------------------
  // Stage 2: chroma and ramp distance
  // ---------------------------------------------------------------------------
  logic [14:0] vs_prod;
  logic [7:0]  chroma;
  logic [5:0]  ramp_t;

  // S is on a /128 scale, so full saturation (127) takes V directly to keep
  // pure hues at full intensity rather than one code short.
  assign vs_prod = 15'(s1_v) * 15'(s1_s);
  assign chroma  = (s1_s == 7'd127) ? s1_v : 8'(vs_prod >> 7);
  assign ramp_t  = s1_sector[0] ? (6'd60 - s1_f) : s1_f;

  logic              s2_valid;
  logic              s2_en;
  logic [23:0]       s2_pixel;
  logic [PASS_W-1:0] s2_pass;
  logic [2:0]        s2_sector;
  logic [7:0]        s2_c;
  logic [5:0]        s2_t;
  logic [7:0]        s2_v;

  // Advance valid and sideband into stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_pass  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_pass  <= s1_pass;
    end
  end

  // Register chroma and ramp distance for the X multiply.
  always_ff @(posedge clk) begin
    s2_en     <= s1_en;
    s2_pixel  <= s1_pixel;
    s2_sector <= s1_sector;
    s2_c      <= chroma;
    s2_t      <= ramp_t;
    s2_v      <= s1_v;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: secondary component X and grey offset m
  // ---------------------------------------------------------------------------
  logic [31:0] x_prod;
  logic [7:0]  x_term;
  logic [7:0]  m_term;

  // X = C*t/60 using a Q16 reciprocal; the rounded-up reciprocal keeps t=60
  // landing exactly on C, and the floor never exceeds C.
  assign x_prod = 32'(s2_c) * 32'(s2_t) * RECIP60;
  assign x_term = 8'(x_prod >> 16);
  assign m_term = s2_v - s2_c;

  logic              s3_valid;
  logic              s3_en;
  logic [23:0]       s3_pixel;
  logic [PASS_W-1:0] s3_pass;
  logic [2:0]        s3_sector;
  logic [7:0]        s3_c;
  logic [7:0]        s3_x;
  logic [7:0]        s3_m;

  // Advance valid and sideband into stage 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_pass  <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_pass  <= s2_pass;
    end
  end

  // Register the three colour terms ahead of the sector map.
  always_ff @(posedge clk) begin
    s3_en     <= s2_en;
    s3_pixel  <= s2_pixel;
    s3_sector <= s2_sector;
    s3_c      <= s2_c;
    s3_x      <= x_term;
    s3_m      <= m_term;
  end

  // ---------------------------------------------------------------------------
  // Stage 4: sector map, add m, select bypass
  // ---------------------------------------------------------------------------
  logic [7:0]  r_term;
  logic [7:0]  g_term;
  logic [7:0]  b_term;
  logic [23:0] rgb;

  // Place C and X on the channels that rise/fall in this sector; the third
  // channel sits at zero before the grey offset is added.
  always_comb begin
    r_term = s3_c;
    g_term = 8'd0;
    b_term = s3_x;
    case (s3_sector)
      3'd0: begin
        r_term = s3_c;
        g_term = s3_x;
        b_term = 8'd0;
      end
      3'd1: begin
        r_term = s3_x;
        g_term = s3_c;
        b_term = 8'd0;
      end
      3'd2: begin
        r_term = 8'd0;
        g_term = s3_c;
        b_term = s3_x;
      end
      3'd3: begin
        r_term = 8'd0;
        g_term = s3_x;
        b_term = s3_c;
      end
      3'd4: begin
        r_term = s3_x;
        g_term = 8'd0;
        b_term = s3_c;
      end
      default: begin
        r_term = s3_c;
        g_term = 8'd0;
        b_term = s3_x;
      end
    endcase
  end

  // Every term is at most C and C + m = V, so these sums cannot wrap.
  assign rgb = {r_term + s3_m, g_term + s3_m, b_term + s3_m};

  // Drive the outputs; reset clears them so no stale pixel escapes a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pixel_out <= 24'd0;
      pass_thru <= '0;
    end else begin
      out_valid <= s3_valid;
      pixel_out <= s3_en ? rgb : s3_pixel;
      pass_thru <= s3_pass;
    end
  end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// tb_hsv_to_rgb: self-checking bench for hsv_to_rgb. Directed vectors with
// hand-computed colours, a reset/latency sequence, and a random stream with
// bubbles, enable toggling and mid-stream resets checked against a model.

module tb_hsv_to_rgb;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [23:0] pixel_in;
  logic [23:0] pass_in;
  logic [23:0] pixel_out;
  logic [23:0] pass_thru;
  logic        out_valid;

  int checks_total  = 0;
  int checks_passed = 0;

  // Expected-output delay line; slot 4 is what the outputs should show now.
  logic        exp_valid [5];
  logic [23:0] exp_pixel [5];
  logic [23:0] exp_pass  [5];

  typedef struct {
    logic        en;
    logic [23:0] pixel;
    logic [23:0] pass;
    logic [23:0] expect_rgb;
  } vec_t;

  vec_t vecs [13];

  hsv_to_rgb #(
    .PASS_W (24),
    .RECIP60(1093)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .pixel_in (pixel_in),
    .pass_in  (pass_in),
    .pixel_out(pixel_out),
    .pass_thru(pass_thru),
    .out_valid(out_valid)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Reference conversion written straight from the HSV formulas.
  function automatic logic [23:0] hsvModel(input logic e, input logic [23:0] px);
    int h, s, v, sec, f, c, t, x, m, r, g, b;
    if (!e) return px;
    h = int'(px[23:15]);
    s = int'(px[14:8]);
    v = int'(px[7:0]);
    if (h >= 360) h = h - 360;
    sec = h / 60;
    f   = h - 60 * sec;
    c   = (s == 127) ? v : ((v * s) >> 7);
    t   = (sec % 2 == 0) ? f : (60 - f);
    x   = (c * t * 1093) >> 16;
    m   = v - c;
    case (sec)
      0:       begin r = c; g = x; b = 0; end
      1:       begin r = x; g = c; b = 0; end
      2:       begin r = 0; g = c; b = x; end
      3:       begin r = 0; g = x; b = c; end
      4:       begin r = x; g = 0; b = c; end
      default: begin r = c; g = 0; b = x; end
    endcase
    return {8'(r + m), 8'(g + m), 8'(b + m)};
  endfunction

  // Drive one cycle of inputs, clock it in, update the expected line, and
  // return at the following falling edge where outputs are stable.
  task automatic applyStimulus(input logic r, input logic v, input logic e,
                               input logic [23:0] px, input logic [23:0] ps);
    rst      = r;
    in_valid = v;
    en       = e;
    pixel_in = px;
    pass_in  = ps;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 5; i++) begin
        exp_valid[i] = 1'b0;
        exp_pixel[i] = 24'd0;
        exp_pass[i]  = 24'd0;
      end
    end else begin
      for (int i = 4; i > 0; i--) begin
        exp_valid[i] = exp_valid[i-1];
        exp_pixel[i] = exp_pixel[i-1];
        exp_pass[i]  = exp_pass[i-1];
      end
      exp_valid[0] = v;
      exp_pixel[0] = hsvModel(e, px);
      exp_pass[0]  = ps;
    end
    @(negedge clk);
  endtask

  // Compare the outputs against explicit expectations.
  task automatic checkOutput(input string name, input logic ev, input logic check_data,
                             input logic [23:0] ep, input logic [23:0] es);
    checks_total++;
    if (out_valid !== ev)
      $display("[TB] FAIL %s out_valid: got %b want %b", name, out_valid, ev);
    else
      checks_passed++;
    if (check_data) begin
      checks_total++;
      if (pixel_out !== ep)
        $display("[TB] FAIL %s pixel_out: got %h want %h", name, pixel_out, ep);
      else
        checks_passed++;
      checks_total++;
      if (pass_thru !== es)
        $display("[TB] FAIL %s pass_thru: got %h want %h", name, pass_thru, es);
      else
        checks_passed++;
    end
  endtask

  // Compare against the head of the expected delay line.
  task automatic checkModel(input string name);
    checkOutput(name, exp_valid[4], exp_valid[4], exp_pixel[4], exp_pass[4]);
  endtask

  // Main test sequence.
  initial begin
    logic [31:0] rnd_px;
    logic [31:0] rnd_ps;
    logic        r_now;

    for (int i = 0; i < 5; i++) begin
      exp_valid[i] = 1'b0;
      exp_pixel[i] = 24'd0;
      exp_pass[i]  = 24'd0;
    end

    vecs[0]  = '{1'b1, {9'd0,   7'd127, 8'd255}, 24'h000101, 24'hFF0000};
    vecs[1]  = '{1'b1, {9'd120, 7'd127, 8'd200}, 24'h000102, 24'h00C800};
    vecs[2]  = '{1'b1, {9'd240, 7'd127, 8'd255}, 24'h000103, 24'h0000FF};
    vecs[3]  = '{1'b1, {9'd30,  7'd127, 8'd255}, 24'h000104, 24'hFF7F00};
    vecs[4]  = '{1'b1, {9'd400, 7'd127, 8'd255}, 24'h000105, 24'hFFAA00};
    vecs[5]  = '{1'b1, {9'd200, 7'd0,   8'h80},  24'h000106, 24'h808080};
    vecs[6]  = '{1'b1, {9'd60,  7'd64,  8'd200}, 24'h000107, 24'hC8C864};
    vecs[7]  = '{1'b0, 24'h123456,               24'hABCDEF, 24'h123456};
    vecs[8]  = '{1'b1, {9'd180, 7'd127, 8'd255}, 24'h000109, 24'h00FFFF};
    vecs[9]  = '{1'b1, {9'd300, 7'd127, 8'd255}, 24'h00010A, 24'hFF00FF};
    vecs[10] = '{1'b1, {9'd359, 7'd127, 8'd255}, 24'h00010B, 24'hFF0004};
    vecs[11] = '{1'b1, {9'd360, 7'd127, 8'd255}, 24'h00010C, 24'hFF0000};
    vecs[12] = '{1'b1, {9'd90,  7'd127, 8'd100}, 24'h00010D, 24'h326400};

    // Reset held two cycles with valid pixels presented.
    applyStimulus(1'b1, 1'b1, 1'b1, {9'd0, 7'd127, 8'd255}, 24'h55AA55);
    checkOutput("reset_edge1", 1'b0, 1'b1, 24'd0, 24'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, {9'd0, 7'd127, 8'd255}, 24'h55AA55);
    checkOutput("reset_edge2", 1'b0, 1'b1, 24'd0, 24'd0);

    // First four post-release pixels must not appear before their 4th edge.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, {9'(k * 70), 7'd127, 8'd255}, 24'h000200 + 24'(k));
      checkOutput($sformatf("post_reset_quiet%0d", k), 1'b0, 1'b0, 24'd0, 24'd0);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 24'd0, 24'd0);
      checkModel($sformatf("post_reset_drain%0d", k));
    end

    // Directed vectors, each isolated by bubbles so latency is exact.
    foreach (vecs[i]) begin
      applyStimulus(1'b0, 1'b1, vecs[i].en, vecs[i].pixel, vecs[i].pass);
      for (int k = 0; k < 3; k++)
        applyStimulus(1'b0, 1'b0, 1'b1, 24'd0, 24'd0);
      checkOutput($sformatf("vec%0d_early", i), 1'b0, 1'b0, 24'd0, 24'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 24'd0, 24'd0);
      checkOutput($sformatf("vec%0d", i), 1'b1, 1'b1, vecs[i].expect_rgb, vecs[i].pass);
    end

    // Random stream with bubbles, enable toggling and resets mid-flight.
    for (int n = 0; n < 300; n++) begin
      rnd_px = $urandom;
      rnd_ps = $urandom;
      r_now  = (n == 150) || (n == 230) || (n == 231);
      applyStimulus(r_now, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    rnd_px[23:0], rnd_ps[23:0]);
      if (r_now)
        checkOutput($sformatf("stream_reset%0d", n), 1'b0, 1'b1, 24'd0, 24'd0);
      else
        checkModel($sformatf("stream%0d", n));
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 24'd0, 24'd0);
      checkModel($sformatf("stream_drain%0d", k));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
